// File: rtl/dsc_mul_seq_pkg.sv
// Shared definitions for the dsc_mul sequencer.
// Provides the FSM state type and the default widths and timeout used by dsc_mul_seq.
package dsc_pkg;

  localparam int unsigned NUM_BITS_DEF   = 10;
  localparam int unsigned NUM_INPUTS_DEF = 3;
  localparam int unsigned Z_W            = NUM_INPUTS_DEF * NUM_BITS_DEF;
  localparam int unsigned CYC_W_DEF      = 34;
  // 2**30 + 64 RUN cycles before a run is abandoned
  localparam longint unsigned TIMEOUT_DEF = 64'd1073741888;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/dsc_mul_seq_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Ports:
//   clk  - clock
//   rst  - synchronous clear (active high)
//   en   - count enable
//   cnt  - current count, sticks at all-ones
module dsc_mul_seq_counter #(
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  // Count enabled cycles, holding at the maximum instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dsc_mul_seq.sv
// Hardware initiator for the dsc_mul deterministic-stochastic multiplier.
// Takes operand triples on a valid/ready port, runs each on dsc_mul
// (hold in reset, release for one cycle, enable until ov) and returns the
// product with the RUN cycle count on a valid/ready result port.
// Optional build macro DSC_MUL_SEQ_CHECK_EN adds res_err, a reference
// product check of the dsc_mul result.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake; in_ready only in IDLE
//   in_a/in_b/in_c      - operands
//   mul_rst/mul_en      - dsc_mul reset and enable
//   mul_a/mul_b/mul_c   - latched operands to dsc_mul
//   mul_z/mul_ov        - dsc_mul product and done flag
//   out_valid/out_ready - result handshake
//   res_z/res_cyc       - captured product and RUN cycle count (incl. ov cycle)
//   res_timeout         - run aborted, res_z forced to 0
//   res_err             - (check build only) product disagrees with a*b*c
//   busy                - sequencer not in IDLE
module dsc_mul_seq
  import dsc_pkg::*;
#(
  parameter int unsigned     NUM_BITS   = NUM_BITS_DEF,
  parameter int unsigned     NUM_INPUTS = NUM_INPUTS_DEF,
  parameter int unsigned     CYC_W      = CYC_W_DEF,
  parameter longint unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_BITS-1:0]            in_a,
  input  logic [NUM_BITS-1:0]            in_b,
  input  logic [NUM_BITS-1:0]            in_c,
  output logic                           mul_rst,
  output logic                           mul_en,
  output logic [NUM_BITS-1:0]            mul_a,
  output logic [NUM_BITS-1:0]            mul_b,
  output logic [NUM_BITS-1:0]            mul_c,
  input  logic [NUM_INPUTS*NUM_BITS-1:0] mul_z,
  input  logic                           mul_ov,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_INPUTS*NUM_BITS-1:0] res_z,
  output logic [CYC_W-1:0]               res_cyc,
  output logic                           res_timeout,
`ifdef DSC_MUL_SEQ_CHECK_EN
  output logic                           res_err,
`endif
  output logic                           busy
);

  localparam int unsigned      PROD_W      = NUM_INPUTS * NUM_BITS;
  localparam logic [CYC_W-1:0] TIMEOUT_CNT = CYC_W'(TIMEOUT);
  localparam logic [CYC_W-1:0] CNT_MAX     = {CYC_W{1'b1}};

  state_e           state;
  logic [CYC_W-1:0] cnt;
  logic [CYC_W-1:0] cnt_inc_c;
  logic             cnt_en_c;
  logic             cnt_rst_c;

  // Cycle counter: cleared while idle, advances only in RUN
  assign cnt_en_c  = (state == RUN);
  assign cnt_rst_c = rst | (state == IDLE);

  dsc_mul_seq_counter #(
    .WIDTH (CYC_W)
  ) u_cnt (
    .clk (clk),
    .rst (cnt_rst_c),
    .en  (cnt_en_c),
    .cnt (cnt)
  );

  // Count including the current RUN cycle, saturating like the counter
  assign cnt_inc_c = (cnt == CNT_MAX) ? cnt : cnt + CYC_W'(1);

`ifdef DSC_MUL_SEQ_CHECK_EN
  logic [PROD_W-1:0] prod_c;

  // Reference product at full result width from the latched operands
  assign prod_c = PROD_W'(mul_a) * PROD_W'(mul_b) * PROD_W'(mul_c);
`endif

  // Sequencer FSM; outputs are registered alongside the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      mul_rst     <= 1'b1;
      mul_en      <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_c       <= '0;
      out_valid   <= 1'b0;
      res_z       <= '0;
      res_cyc     <= '0;
      res_timeout <= 1'b0;
      busy        <= 1'b0;
`ifdef DSC_MUL_SEQ_CHECK_EN
      res_err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_a    <= in_a;
            mul_b    <= in_b;
            mul_c    <= in_c;
            mul_rst  <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end

        // dsc_mul out of reset with stable operands before enabling
        SETUP: begin
          mul_en <= 1'b1;
          state  <= RUN;
        end

        // ov wins over the timeout when both land in the same cycle
        RUN: begin
          if (mul_ov) begin
            res_z       <= mul_z;
            res_cyc     <= cnt_inc_c;
            res_timeout <= 1'b0;
`ifdef DSC_MUL_SEQ_CHECK_EN
            res_err     <= (prod_c != mul_z);
`endif
            mul_en      <= 1'b0;
            mul_rst     <= 1'b1;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else if (cnt_inc_c == TIMEOUT_CNT) begin
            res_z       <= '0;
            res_cyc     <= TIMEOUT_CNT;
            res_timeout <= 1'b1;
`ifdef DSC_MUL_SEQ_CHECK_EN
            res_err     <= 1'b0;
`endif
            mul_en      <= 1'b0;
            mul_rst     <= 1'b1;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end

        // Result held until the consumer takes it
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_mul_seq.sv
module tb_dsc_mul_seq;
  import dsc_pkg::*;

  localparam int unsigned NB  = 10;
  localparam int unsigned ZW  = 30;
  localparam int unsigned CW  = 34;
  localparam int unsigned TMO = 100;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_a, in_b, in_c;
  logic          mul_rst, mul_en;
  logic [NB-1:0] mul_a, mul_b, mul_c;
  logic [ZW-1:0] mul_z;
  logic          mul_ov;
  logic          out_valid, out_ready;
  logic [ZW-1:0] res_z;
  logic [CW-1:0] res_cyc;
  logic          res_timeout;
  logic          busy;
`ifdef DSC_MUL_SEQ_CHECK_EN
  logic          res_err;
`endif

  int     checks   = 0;
  int     failures = 0;
  longint cycle    = 0;

  bit stub_ov0 = 1'b0;
  bit stub_z   = 1'b0;

  dsc_mul_seq #(
    .NUM_BITS   (NB),
    .NUM_INPUTS (3),
    .CYC_W      (CW),
    .TIMEOUT    (64'(TMO))
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_c        (in_c),
    .mul_rst     (mul_rst),
    .mul_en      (mul_en),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_c       (mul_c),
    .mul_z       (mul_z),
    .mul_ov      (mul_ov),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .res_z       (res_z),
    .res_cyc     (res_cyc),
    .res_timeout (res_timeout),
`ifdef DSC_MUL_SEQ_CHECK_EN
    .res_err     (res_err),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural dsc_mul: done after an operand-dependent number of enabled cycles
  logic [5:0] m_k;
  logic [5:0] m_lat;
  assign m_lat = 6'(((int'(mul_a) + int'(mul_b) + int'(mul_c)) % 32) + 1);
  always @(posedge clk) begin
    if (mul_rst) m_k <= '0;
    else if (mul_en && (m_k != m_lat)) m_k <= m_k + 6'd1;
  end
  assign mul_ov = !stub_ov0 && !mul_rst && (m_k == m_lat);
  assign mul_z  = stub_z ? ZW'(5) : ZW'(mul_a) * ZW'(mul_b) * ZW'(mul_c);

  typedef struct {
    logic [ZW-1:0] z;
    logic [CW-1:0] cyc;
    logic          to;
    logic          err;
    longint        t_acc;
  } exp_t;

  exp_t sb[$];

  task automatic send(input int a, input int b, input int c);
    exp_t e;
    int   t;
    longint prod;
    t = 0;
    while (in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_a = NB'(a);
    in_b = NB'(b);
    in_c = NB'(c);
    prod  = longint'(a) * longint'(b) * longint'(c);
    e.to  = stub_ov0;
    e.z   = stub_ov0 ? '0 : (stub_z ? ZW'(5) : ZW'(prod));
    e.cyc = stub_ov0 ? CW'(TMO) : CW'((((a + b + c) % 32) + 1) + 1);
    e.err = !stub_ov0 && stub_z && (prod != 5);
    e.t_acc = cycle;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   t;
    t = 0;
    while (out_valid !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL out_valid_wait out_valid=%b required 1", out_valid);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty queue size=0 required >0");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (res_z !== e.z) begin
      failures++;
      $display("FAIL res_z got=%0d required=%0d", res_z, e.z);
    end
    checks++;
    if (res_cyc !== e.cyc) begin
      failures++;
      $display("FAIL res_cyc got=%0d required=%0d", res_cyc, e.cyc);
    end
    checks++;
    if (res_timeout !== e.to) begin
      failures++;
      $display("FAIL res_timeout got=%b required=%b", res_timeout, e.to);
    end
    checks++;
    if ((cycle - e.t_acc) != longint'(e.cyc) + 2) begin
      failures++;
      $display("FAIL latency got=%0d required=%0d", cycle - e.t_acc, longint'(e.cyc) + 2);
    end
    checks++;
    if (mul_en !== 1'b0 || mul_rst !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL done_ctrl en=%b rst=%b in_ready=%b busy=%b required 0 1 0 1",
               mul_en, mul_rst, in_ready, busy);
    end
`ifdef DSC_MUL_SEQ_CHECK_EN
    checks++;
    if (res_err !== e.err) begin
      failures++;
      $display("FAIL res_err got=%b required=%b", res_err, e.err);
    end
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (res_z !== e.z || res_cyc !== e.cyc || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold_%0d z=%0d cyc=%0d in_ready=%b out_valid=%b required z=%0d cyc=%0d 0 1",
                 i, res_z, res_cyc, in_ready, out_valid, e.z, e.cyc);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || mul_rst !== 1'b1) begin
      failures++;
      $display("FAIL handshake out_valid=%b busy=%b in_ready=%b mul_rst=%b required 0 0 1 1",
               out_valid, busy, in_ready, mul_rst);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || mul_rst !== 1'b1 || mul_en !== 1'b0 || out_valid !== 1'b0 ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl in_ready=%b mul_rst=%b mul_en=%b out_valid=%b busy=%b required 1 1 0 0 0",
               in_ready, mul_rst, mul_en, out_valid, busy);
    end
    checks++;
    if (res_z !== '0 || res_cyc !== '0 || res_timeout !== 1'b0 ||
        mul_a !== '0 || mul_b !== '0 || mul_c !== '0) begin
      failures++;
      $display("FAIL reset_data z=%0d cyc=%0d to=%b a=%0d b=%0d c=%0d required all 0",
               res_z, res_cyc, res_timeout, mul_a, mul_b, mul_c);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    send(15, 15, 15);
    collect(0);
  endtask

  task automatic test_zero_operand();
    send(0, 511, 7);
    collect(0);
  endtask

  task automatic test_backpressure();
    send(100, 200, 300);
    collect(10);
  endtask

  task automatic test_back_to_back();
    send(1, 2, 3);
    collect(0);
    send(1023, 1, 512);
    collect(0);
  endtask

  task automatic test_midrun_reset();
    int t;
    send(7, 8, 9);
    t = 0;
    while (mul_en !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (mul_en !== 1'b1) begin
      failures++;
      $display("FAIL run_entry mul_en=%b required 1", mul_en);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    checks++;
    if (busy !== 1'b0 || mul_rst !== 1'b1 || out_valid !== 1'b0 || mul_en !== 1'b0 ||
        in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrun_rst busy=%b mul_rst=%b out_valid=%b mul_en=%b in_ready=%b required 0 1 0 0 1",
               busy, mul_rst, out_valid, mul_en, in_ready);
    end
    send(1023, 1023, 1023);
    collect(0);
  endtask

  task automatic test_timeout();
    stub_ov0 = 1'b1;
    send(3, 4, 5);
    collect(0);
    stub_ov0 = 1'b0;
  endtask

  task automatic test_check();
`ifdef DSC_MUL_SEQ_CHECK_EN
    stub_z = 1'b1;
    send(2, 2, 2);
    collect(0);
    stub_z = 1'b0;
`endif
    send(2, 2, 2);
    collect(0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_c      = '0;
    test_reset();
    test_basic();
    test_zero_operand();
    test_backpressure();
    test_back_to_back();
    test_midrun_reset();
    test_timeout();
    test_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

endmodule
